// File: rtl/ddr_sch_pkg.sv
// Shared definitions for the DDR read/write burst schedulers.
// State encoding, channel count and burst length width.
package ddr_sch_pkg;

  localparam int unsigned CH_NUM = 4;
  localparam int unsigned IDX_WD = 2;
  localparam int unsigned LEN_WD = 10;

  localparam logic [LEN_WD-1:0] LEN_MAX = '1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StBusy  = 2'd2,
    StDone  = 2'd3
  } sch_state_e;

endpackage

// File: rtl/ddr_wr_sch_if.sv
// Channel-side and controller-side signals of the DDR write scheduler.
// The slave modport is the scheduler; the master modport drives the channels and controller.
interface ddr_wr_sch_if #(
  parameter int unsigned DDR_ADDR_WD = 16,
  parameter int unsigned DDR_DATA_WD = 512
);
  import ddr_sch_pkg::*;

  logic                                    ddr_burst_idle;
  logic [CH_NUM-1:0]                       ch_wr_burst_req;
  logic [CH_NUM-1:0][LEN_WD-1:0]           ch_wr_burst_len;
  logic [CH_NUM-1:0][DDR_ADDR_WD-1:0]      ch_wr_burst_addr;
  logic [CH_NUM-1:0]                       ch_wr_burst_data_req;
  logic [CH_NUM-1:0][DDR_DATA_WD-1:0]      ch_wr_burst_data;
  logic [CH_NUM-1:0]                       ch_wr_burst_finish;

  logic                                    wr_burst_req;
  logic [LEN_WD-1:0]                       wr_burst_len;
  logic [DDR_ADDR_WD-1:0]                  wr_burst_addr;
  logic                                    wr_burst_data_req;
  logic [DDR_DATA_WD-1:0]                  wr_burst_data;
  logic                                    wr_burst_finish;
  logic                                    wr_sch_busy;
  logic                                    wr_len_err;

  modport slave (
    input  ddr_burst_idle, ch_wr_burst_req, ch_wr_burst_len, ch_wr_burst_addr,
           ch_wr_burst_data, wr_burst_data_req, wr_burst_finish,
    output ch_wr_burst_data_req, ch_wr_burst_finish, wr_burst_req, wr_burst_len,
           wr_burst_addr, wr_burst_data, wr_sch_busy, wr_len_err
  );

  modport master (
    output ddr_burst_idle, ch_wr_burst_req, ch_wr_burst_len, ch_wr_burst_addr,
           ch_wr_burst_data, wr_burst_data_req, wr_burst_finish,
    input  ch_wr_burst_data_req, ch_wr_burst_finish, wr_burst_req, wr_burst_len,
           wr_burst_addr, wr_burst_data, wr_sch_busy, wr_len_err
  );

endinterface

// File: rtl/ddr_wr_sch.sv
// Four-channel round-robin write burst scheduler: grants one channel at a time to the
// DDR write burst port and routes data requests, data and finish between them.
module ddr_wr_sch
  import ddr_sch_pkg::*;
#(
  parameter int unsigned DDR_ADDR_WD = 16,
  parameter int unsigned DDR_DATA_WD = 512
) (
  input logic         ddr_clk,
  input logic         ddr_rst_n,
  ddr_wr_sch_if.slave bus
);

  // Nearest requester after `last` wins; `last` itself is lowest priority.
  function automatic logic [IDX_WD-1:0] rr_pick(input logic [CH_NUM-1:0] req,
                                                input logic [IDX_WD-1:0] last);
    logic [IDX_WD-1:0] idx;
    rr_pick = last;
    for (int k = CH_NUM; k >= 1; k--) begin
      idx = last + IDX_WD'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  sch_state_e             state_q, state_d;
  logic [IDX_WD-1:0]      lock_idx_q, lock_idx_d;
  logic [IDX_WD-1:0]      last_gnt_q, last_gnt_d;
  logic [LEN_WD-1:0]      beat_cnt_q, beat_cnt_d;
  logic [LEN_WD-1:0]      len_q, len_d;
  logic [DDR_ADDR_WD-1:0] addr_q, addr_d;

  logic [IDX_WD-1:0]      pick_idx;
  logic [CH_NUM-1:0]      lock_oh;
  logic                   busy_st;
  logic [DDR_DATA_WD-1:0] data_sel;

  assign pick_idx = rr_pick(bus.ch_wr_burst_req, last_gnt_q);
  assign lock_oh  = CH_NUM'(1) << lock_idx_q;
  assign busy_st  = (state_q == StBusy);

  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      state_q    <= StIdle;
      lock_idx_q <= '0;
      last_gnt_q <= IDX_WD'(CH_NUM - 1);
      beat_cnt_q <= '0;
      len_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.ddr_burst_idle && (|bus.ch_wr_burst_req)) begin
          lock_idx_d = pick_idx;
          len_d      = bus.ch_wr_burst_len[pick_idx];
          addr_d     = bus.ch_wr_burst_addr[pick_idx];
          beat_cnt_d = '0;
          state_d    = StIssue;
        end
      end
      StIssue: state_d = StBusy;
      StBusy: begin
        if (bus.wr_burst_data_req && (beat_cnt_q != LEN_MAX)) beat_cnt_d = beat_cnt_q + 1'b1;
        if (bus.wr_burst_finish) state_d = StDone;
      end
      StDone: begin
        last_gnt_d = lock_idx_q;
        state_d    = StIdle;
      end
    endcase
  end

  // Data mux follows lock_idx in every state; only the handshakes are gated by BUSY.
  always_comb begin
    data_sel = bus.ch_wr_burst_data[lock_idx_q];
  end

  assign bus.wr_burst_data        = data_sel;
  assign bus.wr_burst_req         = (state_q == StIssue);
  assign bus.wr_burst_len         = len_q;
  assign bus.wr_burst_addr        = addr_q;
  assign bus.wr_sch_busy          = (state_q != StIdle);
  assign bus.wr_len_err           = (state_q == StDone) && (beat_cnt_q != len_q);
  assign bus.ch_wr_burst_data_req = (busy_st && bus.wr_burst_data_req) ? lock_oh : '0;
  assign bus.ch_wr_burst_finish   = (busy_st && bus.wr_burst_finish) ? lock_oh : '0;

endmodule
